// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions.
//   - mod_q(index): RNS prime table lookup, indices 0..12 (0 returned otherwise).
//   - OP_ADD/OP_SUB/OP_NEG/OP_PASS: modular add/sub op-codes.
package ntt_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;  // (a + b) mod q
  localparam logic [1:0] OP_SUB  = 2'b01;  // (a - b) mod q
  localparam logic [1:0] OP_NEG  = 2'b10;  // (-b) mod q
  localparam logic [1:0] OP_PASS = 2'b11;  // a

  function automatic logic [31:0] mod_q(input int unsigned index);
    logic [31:0] q;
    case (index)
      0:       q = 32'd1063321601;
      1:       q = 32'd1063452673;
      2:       q = 32'd1064697857;
      3:       q = 32'd1065484289;
      4:       q = 32'd1065811969;
      5:       q = 32'd1068236801;
      6:       q = 32'd1068433409;
      7:       q = 32'd1068564481;
      8:       q = 32'd1069219841;
      9:       q = 32'd1070727169;
      10:      q = 32'd1071513601;
      11:      q = 32'd1072496641;
      12:      q = 32'd1073479681;
      default: q = 32'd0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// One residue lane of the modular add/sub pipe: S1 raw compute and S2 correction.
// Data path only; the enclosing pipe owns valid/ready and decides when each stage loads.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en1, en2   load enables for the S1 raw register and the S2 result register
//   op1        op of the beat entering S1
//   op2        op of the beat held in S1 (drives the S2 correction)
//   a, b       residues, 0 <= a, b < Q
//   c          registered result in [0, Q)
module modaddsub_lane
  import ntt_pkg::*;
#(
  parameter int unsigned      WIDTH = 30,
  parameter logic [WIDTH-1:0] Q     = WIDTH'(mod_q(0))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic [1:0]       op1,
  input  logic [1:0]       op2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH:0]   a_x, b_x, q_x;
  logic [WIDTH:0]   raw_d, raw_q;
  logic [WIDTH-1:0] c_d, c_q;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};
  assign q_x = {1'b0, Q};

  // For sub/neg the top bit of the WIDTH+1 difference is the borrow.
  always_comb begin
    raw_d = a_x;
    case (op1)
      OP_ADD:  raw_d = a_x + b_x;
      OP_SUB:  raw_d = a_x - b_x;
      OP_NEG:  raw_d = '0 - b_x;
      default: raw_d = a_x;
    endcase
  end

  // Add results lie in [0, 2q); a borrowed difference wraps back into [0, q) by adding q
  // modulo 2^WIDTH. Neg of 0 produces no borrow and so stays 0.
  always_comb begin
    c_d = raw_q[WIDTH-1:0];
    case (op2)
      OP_ADD: begin
        if (raw_q >= q_x) c_d = raw_q[WIDTH-1:0] - Q;
      end
      OP_SUB, OP_NEG: begin
        if (raw_q[WIDTH]) c_d = raw_q[WIDTH-1:0] + Q;
      end
      default: c_d = raw_q[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= '0;
      c_q   <= '0;
    end else begin
      if (en1) raw_q <= raw_d;
      if (en2) c_q   <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/modular_addsub_pipe.sv
// Multi-lane, two-stage pipelined modular add/subtract unit (mod one RNS prime).
// Optional feature macro: MODADDSUB_RANGE_CHECK_EN adds a sticky `err` output set when an
// accepted beat has any lane with a >= q or b >= q.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready is combinational from out_ready
//   in_op                00 add, 01 sub, 10 neg, 11 pass a
//   in_a, in_b           LANES packed residues, lane i at [i*WIDTH +: WIDTH]
//   in_tag               sideband returned unchanged with the beat
//   out_valid/out_ready  output handshake
//   out_c, out_tag       results and tag, held while out_valid && !out_ready
//   err                  sticky range error (MODADDSUB_RANGE_CHECK_EN only)
module modular_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned     WIDTH      = 30,
  parameter int unsigned     LANES      = 4,
  parameter int unsigned     MOD_INDEX  = 0,
  parameter longint unsigned Q_OVERRIDE = 0,
  parameter int unsigned     TAG_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_c,
  output logic [TAG_W-1:0]       out_tag
`ifdef MODADDSUB_RANGE_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam logic [31:0]      QTable = mod_q(MOD_INDEX);
  localparam logic [WIDTH-1:0] Q      = (Q_OVERRIDE != 0) ? WIDTH'(Q_OVERRIDE) : WIDTH'(QTable);

  logic             v1_q, v2_q;
  logic [1:0]       op1_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic             adv1, adv2, accept, en2;

  // A stage may take a new beat when it is empty or its occupant moves on this edge, so
  // an empty S1 behind a stalled S2 still accepts one beat.
  always_comb begin
    adv2   = !v2_q || out_ready;
    adv1   = !v1_q || adv2;
    accept = in_valid && adv1;
    en2    = adv2 && v1_q;
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out_tag   = tag2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      op1_q  <= OP_ADD;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) v2_q <= v1_q;
      if (accept) begin
        op1_q  <= in_op;
        tag1_q <= in_tag;
      end
      if (en2) tag2_q <= tag1_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gen_lane
    modaddsub_lane #(
      .WIDTH (WIDTH),
      .Q     (Q)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en1 (accept),
      .en2 (en2),
      .op1 (in_op),
      .op2 (op1_q),
      .a   (in_a[i*WIDTH +: WIDTH]),
      .b   (in_b[i*WIDTH +: WIDTH]),
      .c   (out_c[i*WIDTH +: WIDTH])
    );
  end

`ifdef MODADDSUB_RANGE_CHECK_EN
  logic range_bad;
  logic err_q;

  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (in_a[i*WIDTH +: WIDTH] >= Q || in_b[i*WIDTH +: WIDTH] >= Q) range_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && range_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Self-checking bench for modular_addsub_pipe (MOD_INDEX=0, LANES=4, WIDTH=30).
module tb_modular_addsub_pipe;

  localparam int unsigned     W  = 30;
  localparam int unsigned     L  = 4;
  localparam int unsigned     TW = 8;
  localparam int unsigned     LW = L * W;
  localparam longint unsigned Q  = 64'd1063321601;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_op;
  logic [LW-1:0] in_a, in_b, out_c;
  logic [TW-1:0] in_tag, out_tag;
`ifdef MODADDSUB_RANGE_CHECK_EN
  logic          err;
`endif

  modular_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag)
`ifdef MODADDSUB_RANGE_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] c;
    bit            chk;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    nchk = 0;
  int    nfail = 0;
  int    nout = 0;

  task automatic check(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: each lane computed with plain modular arithmetic.
  function automatic logic [LW-1:0] ref_beat(input logic [1:0] op, input logic [LW-1:0] a,
                                             input logic [LW-1:0] b);
    logic [LW-1:0]   r;
    longint unsigned x, y, z;
    r = '0;
    for (int i = 0; i < L; i++) begin
      x = 64'(a[i*W +: W]);
      y = 64'(b[i*W +: W]);
      case (op)
        2'd0:    z = (x + y) % Q;
        2'd1:    z = (x + Q - y) % Q;
        2'd2:    z = (Q - y) % Q;
        default: z = x;
      endcase
      r[i*W +: W] = z[W-1:0];
    end
    return r;
  endfunction

  function automatic bit in_range(input logic [LW-1:0] a, input logic [LW-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < L; i++) begin
      if (64'(a[i*W +: W]) >= Q || 64'(b[i*W +: W]) >= Q) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [LW-1:0] pack4(input longint unsigned l0, input longint unsigned l1,
                                          input longint unsigned l2, input longint unsigned l3);
    logic [LW-1:0] r;
    r = {l3[W-1:0], l2[W-1:0], l1[W-1:0], l0[W-1:0]};
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[i*W +: W] = W'($urandom_range(32'(Q - 1), 0));
    return r;
  endfunction

  // Scoreboard: sampled mid-cycle, so inputs and outputs are stable for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        nout++;
        if (exp_q.size() == 0) begin
          nchk++;
          nfail++;
          $error("FAIL spurious_out: observed tag %0h with no beat outstanding", out_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk) check("out_c", out_c, mon_e.c);
          check("out_tag", LW'(out_tag), LW'(mon_e.tag));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{tag: in_tag, c: ref_beat(in_op, in_a, in_b), chk: in_range(in_a, in_b)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // One beat through an idle pipe; checks latency and the result against a fixed value.
  task automatic one_beat(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                          input logic [TW-1:0] tag, input logic [LW-1:0] exp, input string name);
    out_ready = 1'b1;
    drive(op, a, b, tag);
    #1;
    check({name, "_in_ready"}, LW'(in_ready), LW'(1));
    tick();
    in_valid = 1'b0;
    check({name, "_valid_edge1"}, LW'(out_valid), LW'(0));
    tick();
    check({name, "_valid_edge2"}, LW'(out_valid), LW'(1));
    check({name, "_data"}, out_c, exp);
    check({name, "_tag"}, LW'(out_tag), LW'(tag));
    tick();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check({name, "_drained"}, LW'(exp_q.size()), '0);
  endtask

  initial begin
    int sent, low_cnt, ov_cnt, n0;

    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 2'd0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", LW'(out_valid), LW'(0));
    check("rst_out_c", out_c, '0);
    check("rst_out_tag", LW'(out_tag), '0);
`ifdef MODADDSUB_RANGE_CHECK_EN
    check("rst_err", LW'(err), LW'(0));
`endif
    rst = 1'b0;
    tick();
    check("rst_in_ready", LW'(in_ready), LW'(1));

    // Directed arithmetic cases.
    one_beat(2'd0, pack4(5, Q - 1, Q - 1, 0), pack4(7, 1, Q - 1, 0), 8'h11,
             pack4(12, 0, 1063321599, 0), "add");
    one_beat(2'd1, pack4(3, 9, 0, 100), pack4(5, 9, 0, 1), 8'h22,
             pack4(1063321599, 0, 0, 99), "sub");
    one_beat(2'd2, pack4(17, 5, Q - 1, 0), pack4(0, 1, 2, Q - 1), 8'h33,
             pack4(0, 1063321600, 1063321599, 1), "neg");
    one_beat(2'd3, pack4(42, 0, Q - 1, 7), rand_vec(), 8'h44, pack4(42, 0, Q - 1, 7), "pass");

    // Backpressure: 6 tagged beats, downstream stalled in cycles 3..8.
    sent = 0;
    low_cnt = 0;
    n0 = nout;
    for (int k = 0; k < 20; k++) begin
      out_ready = !(k >= 3 && k <= 8);
      if (sent < 6) drive(2'($urandom_range(3, 0)), rand_vec(), rand_vec(), TW'(sent + 1));
      else in_valid = 1'b0;
      #1;
      if (!in_ready) low_cnt++;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_ready_low_cycles", LW'(low_cnt), LW'(6));
    check("bp_sent", LW'(sent), LW'(6));
    drain("bp");
    check("bp_outputs", LW'(nout - n0), LW'(6));

    // Bubble collapsing: stalled S2 with empty S1 takes one more beat, then fills.
    out_ready = 1'b0;
    drive(2'd0, rand_vec(), rand_vec(), 8'hA1);
    tick();
    in_valid = 1'b0;
    tick();
    check("bubble_s2_held", LW'(out_valid), LW'(1));
    check("bubble_ready", LW'(in_ready), LW'(1));
    drive(2'd1, rand_vec(), rand_vec(), 8'hA2);
    tick();
    in_valid = 1'b0;
    #1;
    check("bubble_full_ready", LW'(in_ready), LW'(0));
    drain("bubble");

    // Full throughput: 100 back-to-back random beats.
    out_ready = 1'b1;
    ov_cnt = 0;
    low_cnt = 0;
    n0 = nout;
    for (int k = 0; k < 102; k++) begin
      if (k < 100) drive(2'($urandom_range(3, 0)), rand_vec(), rand_vec(), TW'($urandom));
      else in_valid = 1'b0;
      #1;
      if (k < 100 && !in_ready) low_cnt++;
      if (k >= 2 && out_valid) ov_cnt++;
      tick();
    end
    check("tput_ready_low", LW'(low_cnt), '0);
    check("tput_valid_cycles", LW'(ov_cnt), LW'(100));
    check("tput_outputs", LW'(nout - n0), LW'(100));
    drain("tput");

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(2'd0, rand_vec(), rand_vec(), 8'hB1);
    tick();
    drive(2'd0, rand_vec(), rand_vec(), 8'hB2);
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_full", LW'(in_ready), LW'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", LW'(out_valid), LW'(0));
    check("mid_rst_out_c", out_c, '0);
    check("mid_rst_out_tag", LW'(out_tag), '0);
    check("mid_rst_in_ready", LW'(in_ready), LW'(1));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    one_beat(2'd1, pack4(3, 9, 1, 2), pack4(5, 9, 0, 2), 8'hC1,
             pack4(1063321599, 0, 1, 0), "post_rst");

`ifdef MODADDSUB_RANGE_CHECK_EN
    // Sticky range error.
    out_ready = 1'b1;
    drive(2'd0, pack4(1, 2, Q, 3), pack4(1, 2, 3, 4), 8'hD1);
    tick();
    in_valid = 1'b0;
    check("err_set", LW'(err), LW'(1));
    for (int k = 0; k < 3; k++) begin
      drive(2'($urandom_range(3, 0)), rand_vec(), rand_vec(), TW'(k));
      tick();
    end
    in_valid = 1'b0;
    drain("err");
    check("err_sticky", LW'(err), LW'(1));
    rst = 1'b1;
    #1;
    check("err_cleared", LW'(err), LW'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
`endif

    drain("final");
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
